crc_check: RTL and testbench

Receive-side CRC verifier paired with the transmit-side CRC generator. It accepts a byte-serial frame (payload followed by the transmitted CRC) over a valid/ready stream. It runs the payload bit-serially through a configurable LFSR, one bit per clock, and holds back the trailing CRC bytes in a window. At end of frame it compares the finalised computed CRC against the received CRC and reports pass/fail.

---
 rtl/crc_check.sv | 264 ++++++++++++++++++++++++++
 tb/tb_crc_check.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc_check.sv
// Receive-side CRC checker. It takes a byte stream made of the payload
// followed by the transmitted CRC. The trailing K bytes are held back in a
// small window while the older bytes are run through a bit-serial LFSR,
// one bit per clock. At end of frame the finalised CRC is compared with
// the CRC assembled from the window.
module crc_check #(
  parameter int MAX_BITS      = 32,
  parameter int MAX_BIT_COUNT = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [MAX_BIT_COUNT-1:0] bitwidth,
  input  logic [MAX_BITS-1:0]      poly,
  input  logic [MAX_BITS-1:0]      init_value,
  input  logic [MAX_BITS-1:0]      xor_out,
  input  logic                     reflect_in,
  input  logic                     reflect_out,
  input  logic [7:0]               in_data,
  input  logic                     in_valid,
  input  logic                     in_last,
  output logic                     in_ready,
  output logic                     done,
  output logic                     crc_ok,
  output logic                     len_err,
  output logic [MAX_BITS-1:0]      crc_calc,
  output logic [MAX_BITS-1:0]      crc_rx
);

  localparam int WIN = MAX_BITS / 8;
  localparam int CW  = $clog2(WIN + 1);

  typedef enum logic [1:0] {IDLE, RECV, SHIFT, DONE} state_t;

  // Number of bit positions above the active CRC width.
  function automatic logic [MAX_BIT_COUNT-1:0] top_gap(input logic [MAX_BIT_COUNT-1:0] bw);
    return MAX_BIT_COUNT'(MAX_BITS - 1) - bw;
  endfunction

  function automatic logic [MAX_BITS-1:0] mask_of(input logic [MAX_BIT_COUNT-1:0] bw);
    logic [MAX_BITS-1:0] ones;
    ones = '1;
    return ones >> top_gap(bw);
  endfunction

  // CRC width in bytes.
  function automatic logic [CW-1:0] k_of(input logic [MAX_BIT_COUNT-1:0] bw);
    logic [MAX_BIT_COUNT:0] t;
    t = {1'b0, bw} + 1'b1;
    return CW'(t >> 3);
  endfunction

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int unsigned i = 0; i < 8; i++) r[i] = v[7 - i];
    return r;
  endfunction

  // Full-width reversal then shift down so that only the low N bits are
  // reversed among themselves.
  function automatic logic [MAX_BITS-1:0] finalize(input logic [MAX_BITS-1:0]      v,
                                                   input logic [MAX_BIT_COUNT-1:0] bw,
                                                   input logic                     ro,
                                                   input logic [MAX_BITS-1:0]      xo);
    logic [MAX_BITS-1:0] r;
    r = v;
    if (ro) begin
      for (int unsigned i = 0; i < MAX_BITS; i++) r[i] = v[MAX_BITS - 1 - i];
      r = r >> top_gap(bw);
    end
    return (r ^ xo) & mask_of(bw);
  endfunction

  state_t                     state_q, state_d;
  logic [MAX_BIT_COUNT-1:0]   bw_q, bw_d;
  logic [MAX_BITS-1:0]        poly_q, poly_d;
  logic [MAX_BITS-1:0]        xo_q, xo_d;
  logic                       rin_q, rin_d;
  logic                       rout_q, rout_d;
  logic [MAX_BITS-1:0]        lfsr_q, lfsr_d;
  logic [7:0]                 sh_q, sh_d;
  logic [2:0]                 bitcnt_q, bitcnt_d;
  logic                       last_q, last_d;
  logic [CW-1:0]              count_q, count_d;
  logic [7:0]                 win_q [WIN];
  logic [7:0]                 win_d [WIN];
  logic                       ok_q, ok_d;
  logic                       len_q, len_d;
  logic [MAX_BITS-1:0]        calc_q, calc_d;
  logic [MAX_BITS-1:0]        rx_q, rx_d;

  logic                       accept;
  logic                       go_done;
  logic [CW-1:0]              k_q;
  logic [CW-1:0]              k_new;
  logic [MAX_BITS-1:0]        rx_asm;
  logic [MAX_BITS-1:0]        calc_new;

  assign in_ready = !rst && ((state_q == IDLE) || (state_q == RECV));
  assign accept   = in_valid && in_ready;
  assign k_q      = k_of(bw_q);

  assign done     = (state_q == DONE);
  assign crc_ok   = ok_q;
  assign len_err  = len_q;
  assign crc_calc = calc_q;
  assign crc_rx   = rx_q;

  // Next-state, window, LFSR and result computation.
  // Results are captured on the edge entering DONE, using the post-update
  // LFSR/window/config so that the direct and post-SHIFT paths share one
  // finalisation.
  always_comb begin
    state_d  = state_q;
    bw_d     = bw_q;
    poly_d   = poly_q;
    xo_d     = xo_q;
    rin_d    = rin_q;
    rout_d   = rout_q;
    lfsr_d   = lfsr_q;
    sh_d     = sh_q;
    bitcnt_d = bitcnt_q;
    last_d   = last_q;
    count_d  = count_q;
    win_d    = win_q;
    ok_d     = ok_q;
    len_d    = len_q;
    calc_d   = calc_q;
    rx_d     = rx_q;
    go_done  = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          bw_d   = bitwidth;
          poly_d = poly & mask_of(bitwidth);
          xo_d   = xor_out;
          rin_d  = reflect_in;
          rout_d = reflect_out;
          lfsr_d = init_value & mask_of(bitwidth);
          for (int unsigned i = 0; i < WIN; i++) win_d[i] = '0;
          win_d[0] = in_data;
          count_d  = CW'(1);
          ok_d     = 1'b0;
          len_d    = 1'b0;
          calc_d   = '0;
          rx_d     = '0;
          if (in_last) begin
            state_d = DONE;
            go_done = 1'b1;
            len_d   = (k_of(bitwidth) != CW'(1));
          end else begin
            state_d = RECV;
          end
        end
      end

      RECV: begin
        if (accept) begin
          if (count_q < k_q) begin
            for (int unsigned i = 0; i < WIN; i++) begin
              if (CW'(i) == count_q) win_d[i] = in_data;
            end
            count_d = count_q + 1'b1;
            if (in_last) begin
              state_d = DONE;
              go_done = 1'b1;
              len_d   = (count_d != k_q);
            end
          end else begin
            // Oldest window byte becomes payload; load it so bit 7 is always next.
            sh_d = rin_q ? rev8(win_q[0]) : win_q[0];
            for (int unsigned i = 0; i < WIN - 1; i++) win_d[i] = win_q[i + 1];
            win_d[WIN-1] = '0;
            for (int unsigned i = 0; i < WIN; i++) begin
              if (CW'(i) == (k_q - 1'b1)) win_d[i] = in_data;
            end
            last_d   = in_last;
            bitcnt_d = '0;
            state_d  = SHIFT;
          end
        end
      end

      SHIFT: begin
        lfsr_d = (lfsr_q << 1) & mask_of(bw_q);
        if (lfsr_q[bw_q] ^ sh_q[7]) lfsr_d = lfsr_d ^ poly_q;
        sh_d     = {sh_q[6:0], 1'b0};
        bitcnt_d = bitcnt_q + 1'b1;
        if (bitcnt_q == 3'd7) begin
          if (last_q) begin
            state_d = DONE;
            go_done = 1'b1;
          end else begin
            state_d = RECV;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
        count_d = '0;
        for (int unsigned i = 0; i < WIN; i++) win_d[i] = '0;
      end

      default: state_d = IDLE;
    endcase

    k_new  = k_of(bw_d);
    rx_asm = '0;
    for (int unsigned i = 0; i < WIN; i++) begin
      if (CW'(i) < k_new) begin
        if (rout_d) rx_asm = rx_asm | (MAX_BITS'(win_d[i]) << (8 * i));
        else        rx_asm = (rx_asm << 8) | MAX_BITS'(win_d[i]);
      end
    end
    calc_new = finalize(lfsr_d, bw_d, rout_d, xo_d);

    if (go_done) begin
      calc_d = calc_new;
      rx_d   = rx_asm;
      ok_d   = (calc_new == rx_asm) && !len_d;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      bw_q     <= '0;
      poly_q   <= '0;
      xo_q     <= '0;
      rin_q    <= 1'b0;
      rout_q   <= 1'b0;
      lfsr_q   <= '0;
      sh_q     <= '0;
      bitcnt_q <= '0;
      last_q   <= 1'b0;
      count_q  <= '0;
      for (int unsigned i = 0; i < WIN; i++) win_q[i] <= '0;
      ok_q     <= 1'b0;
      len_q    <= 1'b0;
      calc_q   <= '0;
      rx_q     <= '0;
    end else begin
      state_q  <= state_d;
      bw_q     <= bw_d;
      poly_q   <= poly_d;
      xo_q     <= xo_d;
      rin_q    <= rin_d;
      rout_q   <= rout_d;
      lfsr_q   <= lfsr_d;
      sh_q     <= sh_d;
      bitcnt_q <= bitcnt_d;
      last_q   <= last_d;
      count_q  <= count_d;
      for (int unsigned i = 0; i < WIN; i++) win_q[i] <= win_d[i];
      ok_q     <= ok_d;
      len_q    <= len_d;
      calc_q   <= calc_d;
      rx_q     <= rx_d;
    end
  end

endmodule

// File: tb/tb_crc_check.sv
// Bench for crc_check: expected frame results are queued when a frame is
// driven and compared when the DUT pulses done.
module tb_crc_check;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  bitwidth;
  logic [31:0] poly;
  logic [31:0] init_value;
  logic [31:0] xor_out;
  logic        reflect_in;
  logic        reflect_out;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic        done;
  logic        crc_ok;
  logic        len_err;
  logic [31:0] crc_calc;
  logic [31:0] crc_rx;

  crc_check #(.MAX_BITS(32), .MAX_BIT_COUNT(5)) dut (
    .clk(clk), .rst(rst), .bitwidth(bitwidth), .poly(poly),
    .init_value(init_value), .xor_out(xor_out), .reflect_in(reflect_in),
    .reflect_out(reflect_out), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .done(done), .crc_ok(crc_ok),
    .len_err(len_err), .crc_calc(crc_calc), .crc_rx(crc_rx)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic        ok;
    logic        len;
    logic        chk;
    logic [31:0] calc;
    logic [31:0] rx;
    int unsigned dcyc;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  logic [7:0]  frm[$];
  int unsigned acc[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int unsigned done_cnt = 0;

  // Scoreboard: every done pulse pops the oldest expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      done_cnt++;
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected_done: done=1 at cycle %0d, required no pending frame", cyc);
      end else begin
        e = exp_q.pop_front();
        if (cyc !== e.dcyc) begin
          n_fail++;
          $display("FAIL sb_done_cycle: got %0d, expected %0d", cyc, e.dcyc);
        end
        n_tests++;
        if (crc_ok !== e.ok) begin
          n_fail++;
          $display("FAIL sb_crc_ok: got %b, expected %b", crc_ok, e.ok);
        end
        n_tests++;
        if (len_err !== e.len) begin
          n_fail++;
          $display("FAIL sb_len_err: got %b, expected %b", len_err, e.len);
        end
        if (e.chk) begin
          n_tests++;
          if (crc_calc !== e.calc) begin
            n_fail++;
            $display("FAIL sb_crc_calc: got %08h, expected %08h", crc_calc, e.calc);
          end
          n_tests++;
          if (crc_rx !== e.rx) begin
            n_fail++;
            $display("FAIL sb_crc_rx: got %08h, expected %08h", crc_rx, e.rx);
          end
        end
      end
    end
  end

  // Straightforward textbook CRC over the first len bytes of frm.
  function automatic logic [31:0] crc_model(input int n, input logic [31:0] p,
                                            input logic [31:0] ini, input logic [31:0] xo,
                                            input bit ri, input bit ro, input int len);
    logic [31:0] msk, crc, r;
    logic [7:0]  b, br;
    msk = (n == 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
    crc = ini & msk;
    for (int i = 0; i < len; i++) begin
      b = frm[i];
      for (int j = 0; j < 8; j++) br[j] = b[7 - j];
      if (ri) b = br;
      crc = crc ^ ({24'd0, b} << (n - 8));
      for (int k = 0; k < 8; k++) begin
        if (crc[n - 1]) crc = ((crc << 1) ^ p) & msk;
        else            crc = (crc << 1) & msk;
      end
    end
    if (ro) begin
      r = '0;
      for (int k = 0; k < n; k++) r[k] = crc[n - 1 - k];
      crc = r;
    end
    return (crc ^ xo) & msk;
  endfunction

  task automatic set_cfg(input logic [4:0] bw, input logic [31:0] p, input logic [31:0] ini,
                         input logic [31:0] xo, input logic ri, input logic ro);
    bitwidth = bw; poly = p; init_value = ini; xor_out = xo;
    reflect_in = ri; reflect_out = ro;
  endtask

  task automatic load_check_string();
    frm = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
  endtask

  // Drives frm with in_valid held high; acc records the cycle of each accept.
  task automatic drive_frame(input bit mark_last);
    int unsigned w;
    acc.delete();
    for (int i = 0; i < frm.size(); i++) begin
      in_data  = frm[i];
      in_last  = mark_last && (i == frm.size() - 1);
      in_valid = 1'b1;
      w = 0;
      while (!in_ready && w < 50) begin
        @(negedge clk);
        w++;
      end
      if (!in_ready) begin
        n_tests++;
        n_fail++;
        $display("FAIL accept_timeout: byte %0d not accepted in 50 cycles, required accept", i);
        break;
      end
      acc.push_back(cyc);
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic push_exp(input logic ok, input logic len, input logic chk,
                          input logic [31:0] calc, input logic [31:0] rx, input bit evict);
    exp_t x;
    x.ok = ok; x.len = len; x.chk = chk; x.calc = calc; x.rx = rx;
    x.dcyc = acc[acc.size() - 1] + (evict ? 9 : 1);
    exp_q.push_back(x);
  endtask

  task automatic wait_done(input int unsigned target, input int unsigned limit);
    int unsigned k = 0;
    while (done_cnt < target && k < limit) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (done_cnt < target) begin
      n_tests++;
      n_fail++;
      $display("FAIL done_timeout: done count %0d after %0d cycles, required %0d", done_cnt, limit, target);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    set_cfg(5'd31, 32'h04C1_1DB7, '1, '1, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    n_tests++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b, expected 0", in_ready);
    end
    n_tests++;
    if ({done, crc_ok, len_err} !== 3'b000 || crc_calc !== 32'd0 || crc_rx !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got done/ok/len=%b%b%b calc=%08h rx=%08h, expected all 0",
               done, crc_ok, len_err, crc_calc, crc_rx);
    end
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: got %b, expected 1", in_ready);
    end
  endtask

  task automatic test_crc32_backpressure();
    int unsigned start;
    set_cfg(5'd31, 32'h04C1_1DB7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1);
    load_check_string();
    frm.push_back(8'h26); frm.push_back(8'h39); frm.push_back(8'hF4); frm.push_back(8'hCB);
    start = done_cnt;
    drive_frame(1'b1);
    push_exp(1'b1, 1'b0, 1'b1, 32'hCBF4_3926, 32'hCBF4_3926, 1'b1);
    n_tests++;
    if (acc.size() !== 13) begin
      n_fail++;
      $display("FAIL bp_accept_count: got %0d, expected 13", acc.size());
    end else begin
      // Four window fills plus the first evicting byte are back to back.
      for (int i = 1; i < 13; i++) begin
        n_tests++;
        if (acc[i] - acc[i - 1] !== ((i <= 4) ? 1 : 9)) begin
          n_fail++;
          $display("FAIL bp_spacing[%0d]: got %0d, expected %0d", i, acc[i] - acc[i - 1], (i <= 4) ? 1 : 9);
        end
      end
    end
    wait_done(start + 1, 40);
    @(negedge clk);
    n_tests++;
    if (in_ready !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL crc32_after_done: got ready=%b done=%b, expected ready=1 done=0", in_ready, done);
    end
  endtask

  task automatic test_crc16();
    int unsigned start;
    set_cfg(5'd15, 32'h0000_1021, 32'h0000_FFFF, 32'd0, 1'b0, 1'b0);
    load_check_string();
    frm.push_back(8'h29); frm.push_back(8'hB1);
    start = done_cnt;
    drive_frame(1'b1);
    push_exp(1'b1, 1'b0, 1'b1, 32'h0000_29B1, 32'h0000_29B1, 1'b1);
    wait_done(start + 1, 40);
  endtask

  task automatic test_back_to_back_crc8();
    int unsigned start;
    set_cfg(5'd7, 32'h0000_0007, 32'd0, 32'd0, 1'b0, 1'b0);
    load_check_string();
    frm.push_back(8'hF4);
    start = done_cnt;
    drive_frame(1'b1);
    push_exp(1'b1, 1'b0, 1'b1, 32'h0000_00F4, 32'h0000_00F4, 1'b1);
    frm[4] = 8'h35 ^ 8'h01;
    drive_frame(1'b1);
    push_exp(1'b0, 1'b0, 1'b1, crc_model(8, 32'h07, 32'd0, 32'd0, 1'b0, 1'b0, 9), 32'h0000_00F4, 1'b1);
    wait_done(start + 2, 300);
  endtask

  task automatic test_short_frame();
    int unsigned start;
    set_cfg(5'd31, 32'h04C1_1DB7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1);
    frm = {8'h31, 8'h32};
    start = done_cnt;
    drive_frame(1'b1);
    push_exp(1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
    wait_done(start + 1, 20);
  endtask

  task automatic test_reset_mid_frame();
    int unsigned start;
    set_cfg(5'd15, 32'h0000_1021, 32'h0000_FFFF, 32'd0, 1'b0, 1'b0);
    frm = {8'h31, 8'h32, 8'h33};
    start = done_cnt;
    drive_frame(1'b0);
    repeat (2) @(negedge clk);
    n_tests++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_in_shift: got in_ready=%b, expected 0", in_ready);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_tests++;
    if ({done, crc_ok, len_err} !== 3'b000 || crc_calc !== 32'd0 || crc_rx !== 32'd0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_outputs: got done/ok/len=%b%b%b calc=%08h rx=%08h ready=%b, expected 0s and ready=1",
               done, crc_ok, len_err, crc_calc, crc_rx, in_ready);
    end
    repeat (15) @(negedge clk);
    n_tests++;
    if (done_cnt !== start) begin
      n_fail++;
      $display("FAIL abort_no_done: got %0d done pulses, expected 0", done_cnt - start);
    end
    load_check_string();
    frm.push_back(8'h29); frm.push_back(8'hB1);
    drive_frame(1'b1);
    push_exp(1'b1, 1'b0, 1'b1, 32'h0000_29B1, 32'h0000_29B1, 1'b1);
    wait_done(start + 1, 40);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_crc32_backpressure();
    test_crc16();
    test_back_to_back_crc8();
    test_short_frame();
    test_reset_mid_frame();
    repeat (20) @(negedge clk);
    n_tests++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL sb_pending: got %0d unmatched expectations, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
